// File: rtl/clk_div_ctrl.sv
// Glitch-free ratio reconfiguration sequencer for clk_div.
// Define CLK_DIV_CTRL_TIMEOUT_EN to bound the WAIT_LOW phase.
module clk_div_ctrl #(
  parameter int RATIO_WIDTH    = 8,
  parameter int DEFAULT_RATIO  = 2,
  parameter int RST_CYCLES     = 2,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_valid,
  input  logic [RATIO_WIDTH-1:0] i_req_ratio,
  output logic                   o_req_ready,
  input  logic                   i_div_clk,
  output logic [RATIO_WIDTH-1:0] o_div_ratio,
  output logic                   o_div_rst_n,
  output logic                   o_clk_en,
  output logic                   o_busy,
  output logic                   o_err
);

  localparam int RS_MAX =
    (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
  localparam int CNT_MAX =
    (TIMEOUT_CYCLES > RS_MAX) ? TIMEOUT_CYCLES : RS_MAX;
`else
  localparam int CNT_MAX = RS_MAX;
`endif
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [RATIO_WIDTH-1:0] DEF_R =
    RATIO_WIDTH'(DEFAULT_RATIO);
  localparam logic [RATIO_WIDTH-1:0] MIN_R =
    RATIO_WIDTH'(2);

  if (DEFAULT_RATIO < 2 || RST_CYCLES < 1 ||
      SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("clk_div_ctrl: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_RST,
    S_SETTLE,
    S_IDLE,
    S_WAIT,
    S_GATE
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [RATIO_WIDTH-1:0] pend;

  // Reset is itself an entry into RST, so the counter starts loaded.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_RST;
      cnt         <= CW'(RST_CYCLES - 1);
      pend        <= DEF_R;
      o_div_ratio <= DEF_R;
      o_div_rst_n <= 1'b0;
      o_clk_en    <= 1'b0;
      o_req_ready <= 1'b0;
      o_busy      <= 1'b1;
      o_err       <= 1'b0;
    end else begin
      o_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_req_valid) begin
            if (i_req_ratio < MIN_R) begin
              o_err <= 1'b1;
            end else if (i_req_ratio != o_div_ratio) begin
              pend        <= i_req_ratio;
              state       <= S_WAIT;
              o_req_ready <= 1'b0;
              o_busy      <= 1'b1;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
              cnt         <= CW'(TIMEOUT_CYCLES - 1);
`endif
            end
          end
        end
        S_WAIT: begin
          if (!i_div_clk) begin
            state    <= S_GATE;
            o_clk_en <= 1'b0;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
          end else if (cnt == '0) begin
            state    <= S_GATE;
            o_clk_en <= 1'b0;
            o_err    <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
`endif
          end
        end
        S_GATE: begin
          state       <= S_RST;
          o_div_ratio <= pend;
          o_div_rst_n <= 1'b0;
          cnt         <= CW'(RST_CYCLES - 1);
        end
        S_RST: begin
          if (cnt == '0) begin
            state       <= S_SETTLE;
            o_div_rst_n <= 1'b1;
            cnt         <= CW'(SETTLE_CYCLES - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt == '0) begin
            state       <= S_IDLE;
            o_clk_en    <= 1'b1;
            o_req_ready <= 1'b1;
            o_busy      <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: vector table plus
// hand-written reset, abort and stuck-high sequences.
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] ratio;
  logic       div_clk;
  logic       ready;
  logic [7:0] div_ratio;
  logic       div_rst_n;
  logic       clk_en;
  logic       busy;
  logic       err;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  clk_div_ctrl dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req_valid(valid),
    .i_req_ratio(ratio),
    .o_req_ready(ready),
    .i_div_clk  (div_clk),
    .o_div_ratio(div_ratio),
    .o_div_rst_n(div_rst_n),
    .o_clk_en   (clk_en),
    .o_busy     (busy),
    .o_err      (err)
  );

  // expected bundle: {ready, clk_en, div_rst_n, busy, err, ratio}
  typedef struct {
    logic        v;
    logic [7:0]  r;
    logic        d;
    logic [12:0] exp;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  function automatic logic [12:0] ex(
    logic rdy, logic en, logic rn, logic b, logic e,
    logic [7:0] rt
  );
    return {rdy, en, rn, b, e, rt};
  endfunction

  function automatic logic [12:0] outs();
    return {ready, clk_en, div_rst_n, busy, err, div_ratio};
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for ready with a bound; an expired bound is a miscompare.
  task automatic wait_ready(string name, int lim);
    int k;
    k = 0;
    while (ready !== 1'b1 && k < lim) begin
      step();
      k++;
    end
    chk(name, 32'(ready), 32'd1);
  endtask

  int errs;
  int drops;
  int k;

  initial begin
    tbl[0]  = '{1'b1, 8'd1, 1'b0, ex(1, 1, 1, 0, 1, 8'd2)};
    tbl[1]  = '{1'b0, 8'd1, 1'b0, ex(1, 1, 1, 0, 0, 8'd2)};
    tbl[2]  = '{1'b1, 8'd0, 1'b0, ex(1, 1, 1, 0, 1, 8'd2)};
    tbl[3]  = '{1'b0, 8'd0, 1'b0, ex(1, 1, 1, 0, 0, 8'd2)};
    tbl[4]  = '{1'b1, 8'd2, 1'b0, ex(1, 1, 1, 0, 0, 8'd2)};
    tbl[5]  = '{1'b1, 8'd5, 1'b0, ex(0, 1, 1, 1, 0, 8'd2)};
    tbl[6]  = '{1'b1, 8'd7, 1'b0, ex(0, 0, 1, 1, 0, 8'd2)};
    tbl[7]  = '{1'b1, 8'd7, 1'b0, ex(0, 0, 0, 1, 0, 8'd5)};
    tbl[8]  = '{1'b0, 8'd0, 1'b1, ex(0, 0, 0, 1, 0, 8'd5)};
    tbl[9]  = '{1'b0, 8'd0, 1'b0, ex(0, 0, 1, 1, 0, 8'd5)};
    tbl[10] = '{1'b0, 8'd0, 1'b1, ex(0, 0, 1, 1, 0, 8'd5)};
    tbl[11] = '{1'b0, 8'd0, 1'b0, ex(0, 0, 1, 1, 0, 8'd5)};
    tbl[12] = '{1'b0, 8'd0, 1'b0, ex(0, 0, 1, 1, 0, 8'd5)};
    tbl[13] = '{1'b0, 8'd0, 1'b0, ex(1, 1, 1, 0, 0, 8'd5)};
    tbl[14] = '{1'b1, 8'd3, 1'b1, ex(0, 1, 1, 1, 0, 8'd5)};
    tbl[15] = '{1'b0, 8'd3, 1'b1, ex(0, 1, 1, 1, 0, 8'd5)};
    tbl[16] = '{1'b0, 8'd3, 1'b0, ex(0, 0, 1, 1, 0, 8'd5)};
    tbl[17] = '{1'b0, 8'd0, 1'b0, ex(0, 0, 0, 1, 0, 8'd3)};
    tbl[18] = '{1'b0, 8'd0, 1'b0, ex(0, 0, 0, 1, 0, 8'd3)};
    tbl[19] = '{1'b0, 8'd0, 1'b0, ex(0, 0, 1, 1, 0, 8'd3)};
    tbl[20] = '{1'b0, 8'd0, 1'b0, ex(0, 0, 1, 1, 0, 8'd3)};
    tbl[21] = '{1'b0, 8'd0, 1'b0, ex(0, 0, 1, 1, 0, 8'd3)};
    tbl[22] = '{1'b0, 8'd0, 1'b0, ex(0, 0, 1, 1, 0, 8'd3)};
    tbl[23] = '{1'b1, 8'd3, 1'b0, ex(1, 1, 1, 0, 0, 8'd3)};

    rst     = 1'b1;
    valid   = 1'b0;
    ratio   = 8'd0;
    div_clk = 1'b0;
    step();
    chk("reset_vals", 32'(outs()), 32'(ex(0, 0, 0, 1, 0, 8'd2)));

    // release: RST 2 cycles, SETTLE 4, IDLE at cycle 6
    rst = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c < 2)
        chk($sformatf("boot_rst_c%0d", c), 32'(outs()),
            32'(ex(0, 0, 0, 1, 0, 8'd2)));
      else if (c < 6)
        chk($sformatf("boot_settle_c%0d", c), 32'(outs()),
            32'(ex(0, 0, 1, 1, 0, 8'd2)));
      else
        chk("boot_idle", 32'(outs()),
            32'(ex(1, 1, 1, 0, 0, 8'd2)));
    end

    for (int i = 0; i < NV; i++) begin
      valid   = tbl[i].v;
      ratio   = tbl[i].r;
      div_clk = tbl[i].d;
      step();
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end

    // async reset while in RST for a request of 9
    valid   = 1'b1;
    ratio   = 8'd9;
    div_clk = 1'b0;
    step();
    valid = 1'b0;
    step();
    step();
    chk("abort_in_rst", 32'(outs()), 32'(ex(0, 0, 0, 1, 0, 8'd9)));
    #2 rst = 1'b1;
    #1;
    chk("abort_async", 32'(outs()), 32'(ex(0, 0, 0, 1, 0, 8'd2)));
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) step();
    chk("abort_idle", 32'(outs()), 32'(ex(1, 1, 1, 0, 0, 8'd2)));

    // stuck-high divided clock with a request for 3
    valid   = 1'b1;
    ratio   = 8'd3;
    div_clk = 1'b1;
    step();
    valid = 1'b0;
    chk("stuck_wait", 32'(outs()), 32'(ex(0, 1, 1, 1, 0, 8'd2)));
    errs  = 0;
    drops = 0;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
    k = 0;
    while (clk_en === 1'b1 && k < 600) begin
      step();
      k++;
      if (err === 1'b1) errs++;
    end
    chk("timeout_cycles", 32'(k), 32'd512);
    chk("timeout_err", 32'(err), 32'd1);
    step();
    if (err === 1'b1) errs++;
    chk("timeout_err_pulse", 32'(err), 32'd0);
    wait_ready("timeout_done", 20);
    chk("timeout_errs", 32'(errs), 32'd1);
    chk("timeout_ratio", 32'(div_ratio), 32'd3);
`else
    for (int c = 0; c < 600; c++) begin
      step();
      if (err === 1'b1) errs++;
      if (clk_en !== 1'b1) drops++;
    end
    chk("stuck_no_drop", 32'(drops), 32'd0);
    chk("stuck_no_err", 32'(errs), 32'd0);
    chk("stuck_busy", 32'(busy), 32'd1);
    div_clk = 1'b0;
    step();
    chk("stuck_gate", 32'(outs()), 32'(ex(0, 0, 1, 1, 0, 8'd2)));
    wait_ready("stuck_done", 20);
    chk("stuck_ratio", 32'(div_ratio), 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_fail);
    $finish;
  end

endmodule
